dispatch_arbiter_n: RTL and testbench

Parametrised N-lane instruction dispatch arbiter between fetch/decode and the per-lane instruction FIFOs. It accepts one 32-bit instruction per cycle and keeps a per-lane in-flight register history. Colliding instructions are steered to the lane that holds the conflicting register; non-colliding ones are spread round-robin. It stalls the producer when the required lane is full or has no free history slots.

---
 rtl/dispatch_arbiter_n.sv | 162 ++++++++++++++++
 tb/tb_dispatch_arbiter_n.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_arbiter_n.sv
// N-lane instruction dispatch arbiter: hazard-steered / round-robin lane selection with per-lane in-flight history.
// Optional macro ARB_OVERRIDE_EN enables software lane override via in_instr[28:26].
module dispatch_arbiter_n #(
    parameter int unsigned N_LANES    = 2,
    parameter int unsigned HIST_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [31:0]        in_instr,
    output logic               in_ready,
    input  logic [N_LANES-1:0] lane_full,
    input  logic [N_LANES-1:0] lane_retire,
    output logic [N_LANES-1:0] FIFO_en,
    output logic [31:0]        instr_out
);

    localparam int unsigned LW = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam int unsigned CW = $clog2(HIST_DEPTH + 1);
    localparam int unsigned PW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;

    typedef struct packed {
        logic [4:0] dest;
        logic       dest_we;
        logic [4:0] src_a;
        logic [4:0] src_b;
    } hist_entry_t;

    hist_entry_t       hist_q  [N_LANES][HIST_DEPTH];
    logic [CW-1:0]     count_q [N_LANES];
    logic [LW-1:0]     rr_q;

    hist_entry_t       new_entry;
    logic [N_LANES-1:0] coll_c;
    logic [N_LANES-1:0] avail_c;
    logic [N_LANES-1:0] retire_c;
    logic [N_LANES-1:0] push_c;
    logic [2:0]        coll_cnt;
    logic [LW-1:0]     coll_lane;
    logic [LW-1:0]     rr_lane;
    logic [LW-1:0]     cand;
    logic              rr_found;
    logic [LW-1:0]     target_c;
    logic              has_target_c;
    logic              rr_pick_c;
    logic              accept_c;

    assign new_entry.dest    = in_instr[20:16];
    assign new_entry.dest_we = in_instr[21];
    assign new_entry.src_a   = in_instr[15:11];
    assign new_entry.src_b   = in_instr[4:0];

    // Per-lane hazard detection against valid history entries; src-src overlap is not a hazard.
    always_comb begin
        coll_c  = '0;
        avail_c = '0;
        for (int i = 0; i < int'(N_LANES); i++) begin
            avail_c[i] = !lane_full[i] && (count_q[i] < CW'(HIST_DEPTH));
            for (int j = 0; j < int'(HIST_DEPTH); j++) begin
                if (CW'(j) < count_q[i]) begin
                    if ((hist_q[i][j].dest_we &&
                         ((new_entry.dest_we && hist_q[i][j].dest == new_entry.dest) ||
                          hist_q[i][j].dest == new_entry.src_a ||
                          hist_q[i][j].dest == new_entry.src_b)) ||
                        (new_entry.dest_we &&
                         (new_entry.dest == hist_q[i][j].src_a ||
                          new_entry.dest == hist_q[i][j].src_b))) begin
                        coll_c[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Target selection: override, then single collider, then round-robin over available lanes.
    always_comb begin
        coll_cnt     = '0;
        coll_lane    = '0;
        rr_lane      = '0;
        cand         = '0;
        rr_found     = 1'b0;
        target_c     = '0;
        has_target_c = 1'b0;
        rr_pick_c    = 1'b0;
        for (int i = 0; i < int'(N_LANES); i++) begin
            if (coll_c[i]) begin
                coll_cnt  = coll_cnt + 3'd1;
                coll_lane = LW'(i);
            end
        end
        for (int unsigned k = 0; k < N_LANES; k++) begin
            cand = LW'((32'(rr_q) + k) % N_LANES);
            if (!rr_found && avail_c[cand]) begin
                rr_found = 1'b1;
                rr_lane  = cand;
            end
        end
        if (coll_cnt == 3'd1) begin
            target_c     = coll_lane;
            has_target_c = 1'b1;
        end else if (coll_cnt == 3'd0) begin
            target_c     = rr_lane;
            has_target_c = rr_found;
            rr_pick_c    = rr_found;
        end
`ifdef ARB_OVERRIDE_EN
        if (in_instr[28]) begin
            target_c     = LW'(32'({in_instr[26], in_instr[27]}) % N_LANES);
            has_target_c = 1'b1;
            rr_pick_c    = 1'b0;
        end
`endif
    end

    assign in_ready = !reset && has_target_c && avail_c[target_c];
    assign accept_c = in_valid && in_ready;

    always_comb begin
        retire_c = '0;
        push_c   = '0;
        for (int i = 0; i < int'(N_LANES); i++) begin
            retire_c[i] = lane_retire[i] && (count_q[i] != '0);
            push_c[i]   = accept_c && (target_c == LW'(i));
        end
    end

    // History shifts toward the head on retire; a same-cycle push lands in the freed tail slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            FIFO_en   <= '0;
            instr_out <= '0;
            rr_q      <= '0;
            for (int i = 0; i < int'(N_LANES); i++) begin
                count_q[i] <= '0;
                for (int j = 0; j < int'(HIST_DEPTH); j++) begin
                    hist_q[i][j] <= '0;
                end
            end
        end else begin
            FIFO_en <= '0;
            if (accept_c) begin
                FIFO_en   <= N_LANES'(1) << target_c;
                instr_out <= in_instr;
                if (rr_pick_c) begin
                    rr_q <= (target_c == LW'(N_LANES - 1)) ? '0 : target_c + LW'(1);
                end
            end
            for (int i = 0; i < int'(N_LANES); i++) begin
                if (retire_c[i]) begin
                    for (int j = 0; j < int'(HIST_DEPTH) - 1; j++) begin
                        hist_q[i][j] <= hist_q[i][j+1];
                    end
                end
                if (push_c[i]) begin
                    hist_q[i][PW'(retire_c[i] ? count_q[i] - CW'(1) : count_q[i])] <= new_entry;
                end
                count_q[i] <= count_q[i] + CW'(push_c[i]) - CW'(retire_c[i]);
            end
        end
    end

endmodule

// File: tb/tb_dispatch_arbiter_n.sv
// Self-checking bench for dispatch_arbiter_n (N_LANES=2, HIST_DEPTH=2); honours ARB_OVERRIDE_EN.
module tb_dispatch_arbiter_n;

    localparam int unsigned NL = 2;
    localparam int unsigned HD = 2;
`ifdef ARB_OVERRIDE_EN
    localparam bit OVR = 1'b1;
`else
    localparam bit OVR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [31:0]   in_instr;
    logic          in_ready;
    logic [NL-1:0] lane_full;
    logic [NL-1:0] lane_retire;
    logic [NL-1:0] FIFO_en;
    logic [31:0]   instr_out;

    dispatch_arbiter_n #(.N_LANES(NL), .HIST_DEPTH(HD)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .lane_full(lane_full), .lane_retire(lane_retire),
        .FIFO_en(FIFO_en), .instr_out(instr_out)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] instr; int lane; } exp_t;
    typedef struct { bit rst; logic [31:0] instr; int lane; } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   pushes = 0;
    int   pulses = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic expect_dispatch(input logic [31:0] instr, input int lane);
        sb_q.push_back('{instr, lane});
        pushes++;
    endtask

    // Every dispatch pulse is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mon_en && FIFO_en !== '0) begin
            pulses++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: FIFO_en=%b instr_out=%h with nothing expected", FIFO_en, instr_out);
            end else begin
                mon_e = sb_q.pop_front();
                check("fifo_en", 32'(FIFO_en), 32'(1 << mon_e.lane));
                check("instr_out", instr_out, mon_e.instr);
            end
        end
    end

    task automatic do_reset();
        reset       = 1'b1;
        in_valid    = 1'b0;
        lane_full   = '0;
        lane_retire = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Presents instr until accepted (bounded); returns one tick after the accepting edge.
    task automatic send(input logic [31:0] instr, input int lane, input string name);
        int waitc;
        waitc    = 0;
        in_instr = instr;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waitc < 20) begin
            waitc++;
            @(negedge clk);
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL %s_accept: in_ready=0 after %0d cycles, expected 1", name, waitc);
            in_valid = 1'b0;
        end else begin
            expect_dispatch(instr, lane);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic stall_check(input string name, input int n);
        @(negedge clk);
        repeat (n) begin
            @(negedge clk);
            check({name, "_ready"}, 32'(in_ready), 32'd0);
            check({name, "_en"}, 32'(FIFO_en), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    vec_t vecs[9];

    initial begin
        vecs[0] = '{1'b1, 32'h00308002, 0};
        vecs[1] = '{1'b0, 32'h00001000, 1};
        vecs[2] = '{1'b0, 32'h00001000, 0};
        vecs[3] = '{1'b1, 32'h00308002, 0};
        vecs[4] = '{1'b0, 32'h00238000, 0};
        vecs[5] = '{1'b0, 32'h00001000, 1};
        vecs[6] = '{1'b1, 32'h00308002, 0};
        vecs[7] = '{1'b0, 32'h10000000, OVR ? 0 : 1};
        vecs[8] = '{1'b0, 32'h18000000, OVR ? 1 : 0};

        reset       = 1'b1;
        in_valid    = 1'b1;
        in_instr    = 32'h00001000;
        lane_full   = '0;
        lane_retire = '0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_fifo_en", 32'(FIFO_en), 32'd0);
        check("rst_instr_out", instr_out, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        do_reset();

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].rst) do_reset();
            send(vecs[i].instr, vecs[i].lane, $sformatf("vec%0d", i));
        end

        // Full target lane stalls a collider; release dispatches the held instruction.
        do_reset();
        send(32'h00308002, 0, "full_seed");
        lane_full = 2'b01;
        in_instr  = 32'h00238000;
        in_valid  = 1'b1;
        stall_check("full_stall", 5);
        @(posedge clk); #1;
        lane_full = '0;
        send(32'h00238000, 0, "full_release");

        // History exhaustion, retire release, then simultaneous retire + dispatch.
        do_reset();
        send(32'h00308002, 0, "hist_a");
        send(32'h00238000, 0, "hist_b");
        in_instr = 32'h00001800;
        in_valid = 1'b1;
        stall_check("hist_stall", 3);
        @(posedge clk); #1;
        lane_retire = 2'b01;
        @(negedge clk);
        check("retire_pending_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        lane_retire = '0;
        @(negedge clk);
        check("retire_release_ready", 32'(in_ready), 32'd1);
        if (in_ready) expect_dispatch(32'h00001800, 0);
        @(posedge clk); #1;
        in_valid    = 1'b0;
        lane_retire = 2'b01;
        @(posedge clk); #1;
        in_instr = 32'h00230000;
        in_valid = 1'b1;
        @(negedge clk);
        check("simul_ready", 32'(in_ready), 32'd1);
        if (in_ready) expect_dispatch(32'h00230000, 0);
        @(posedge clk); #1;
        lane_retire = '0;
        in_valid    = 1'b0;
        send(32'h00001800, 0, "after_simul");
        in_instr = 32'h00001800;
        in_valid = 1'b1;
        stall_check("simul_full", 3);
        in_valid = 1'b0;

        // Reset while a collider is stalled on lane 1.
        do_reset();
        send(32'h00308002, 0, "rst_a");
        send(32'h00000000, 1, "rst_b");
        send(32'h00200000, 1, "rst_c");
        in_instr = 32'h00000000;
        in_valid = 1'b1;
        stall_check("rst_stall", 2);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_stall_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_after_en", 32'(FIFO_en), 32'd0);
        check("rst_after_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        send(32'h00000000, 0, "rst_rr");

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        check("pulse_count", 32'(pulses), 32'(pushes));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
